// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constant control words for the pipeline freeze/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    MEM_WAIT
  } pctl_state_t;

  // Control word carried by ID/EXE; a bubble loads this all-zero word.
  typedef struct packed {
    logic wb_en;
    logic mem_r;
    logic mem_w;
  } exe_ctrl_t;

  localparam exe_ctrl_t NOP_CTRL = '{wb_en: 1'b0, mem_r: 1'b0, mem_w: 1'b0};

  typedef struct packed {
    logic freeze_pc;
    logic freeze_if_id;
    logic flush_if_id;
    logic bubble_id_exe;
    logic freeze_back;
  } pctl_ctrl_t;

  localparam pctl_ctrl_t CTRL_NONE = '0;

  localparam pctl_ctrl_t CTRL_MEM_FREEZE = '{
    freeze_pc: 1'b1, freeze_if_id: 1'b1, flush_if_id: 1'b0, bubble_id_exe: 1'b0,
    freeze_back: 1'b1
  };

  localparam pctl_ctrl_t CTRL_BRANCH_FLUSH = '{
    freeze_pc: 1'b0, freeze_if_id: 1'b0, flush_if_id: 1'b1, bubble_id_exe: 1'b1,
    freeze_back: 1'b0
  };

  localparam pctl_ctrl_t CTRL_FLUSH_ONLY = '{
    freeze_pc: 1'b0, freeze_if_id: 1'b0, flush_if_id: 1'b1, bubble_id_exe: 1'b0,
    freeze_back: 1'b0
  };

  localparam pctl_ctrl_t CTRL_HAZARD_STALL = '{
    freeze_pc: 1'b1, freeze_if_id: 1'b1, flush_if_id: 1'b0, bubble_id_exe: 1'b1,
    freeze_back: 1'b0
  };

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Freeze/flush sequencer for the 5-stage pipeline: mem-wait > branch flush > data hazard.
// Controls are combinational from state and inputs; state and counters are registered.
module pipeline_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             bubble_id_exe,
  output logic             freeze_back,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  pctl_state_t       state_q, state_d;
  logic [2:0]        flush_left_q, flush_left_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  pctl_ctrl_t        ctrl;
  logic              stall_inc, flush_inc, memwait_inc;
  logic              mem_stall;

  assign mem_stall = mem_req & ~mem_ready;

  always_comb begin
    state_d       = state_q;
    flush_left_d  = flush_left_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    ctrl          = CTRL_NONE;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    memwait_inc   = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          ctrl        = CTRL_MEM_FREEZE;
          memwait_inc = 1'b1;
          state_d     = MEM_WAIT;
        end else if (branch_taken) begin
          ctrl      = CTRL_BRANCH_FLUSH;
          flush_inc = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            flush_left_d = FLUSH_RELOAD;
            state_d      = FLUSH;
          end
        end else if (hazard_detected) begin
          ctrl      = CTRL_HAZARD_STALL;
          stall_inc = 1'b1;
        end
      end

      FLUSH: begin
        if (mem_stall) begin
          // flush_left is held so the flush resumes once memory completes
          ctrl        = CTRL_MEM_FREEZE;
          memwait_inc = 1'b1;
          state_d     = MEM_WAIT;
        end else if (branch_taken) begin
          ctrl         = CTRL_BRANCH_FLUSH;
          flush_inc    = 1'b1;
          flush_left_d = FLUSH_RELOAD;
        end else begin
          ctrl = CTRL_FLUSH_ONLY;
          if (flush_left_q <= 3'd1) begin
            flush_left_d = 3'd0;
            state_d      = RUN;
          end else begin
            flush_left_d = flush_left_q - 3'd1;
          end
        end
      end

      MEM_WAIT: begin
        if (mem_ready) begin
          wait_cnt_d = '0;
          state_d    = (flush_left_q != 3'd0) ? FLUSH : RUN;
        end else begin
          ctrl        = CTRL_MEM_FREEZE;
          memwait_inc = 1'b1;
        end
      end

      default: begin
        state_d      = RUN;
        flush_left_d = 3'd0;
      end
    endcase

    // Every mem-freeze cycle, including the entry cycle in RUN/FLUSH, advances the timeout.
    if (memwait_inc) begin
      if (wait_cnt_q != WAIT_MAX) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
      if ((wait_cnt_q != WAIT_MAX) ? (wait_cnt_q + 1'b1 == WAIT_MAX) : 1'b1) begin
        mem_timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      flush_left_q  <= 3'd0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_left_q  <= flush_left_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign freeze_pc     = rst_n & ctrl.freeze_pc;
  assign freeze_if_id  = rst_n & ctrl.freeze_if_id;
  assign flush_if_id   = rst_n & ctrl.flush_if_id;
  assign bubble_id_exe = rst_n & ctrl.bubble_id_exe;
  assign freeze_back   = rst_n & ctrl.freeze_back;
  assign mem_timeout   = mem_timeout_q;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (stall_inc),
    .clr  (cnt_clr),
    .q    (stall_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (flush_inc),
    .clr  (cnt_clr),
    .q    (flush_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_memwait_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (memwait_inc),
    .clr  (cnt_clr),
    .q    (memwait_cnt)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: two parameterisations driven by shared stimulus,
// each checked against a cycle-level behavioural model.
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hazard_detected = 1'b0;
  logic branch_taken = 1'b0;
  logic mem_req = 1'b0;
  logic mem_ready = 1'b0;
  logic cnt_clr = 1'b0;

  logic [1:0]  o_fpc, o_fif, o_flif, o_bub, o_fbk, o_mto;
  logic [15:0] sc0, fc0, mw0;
  logic [1:0]  sc1, fc1, mw1;

  int n_checks = 0;
  int n_fail = 0;

  // Model parameters and state, one slot per DUT instance.
  int p_fc[2] = '{2, 3};
  int p_mt[2] = '{4, 6};
  int p_max[2] = '{65535, 3};
  bit m_waiting[2];
  int m_flush_left[2];
  int m_wait[2];
  bit m_to[2];
  int m_stall[2];
  int m_flush[2];
  int m_memw[2];
  bit e_fpc[2], e_fif[2], e_flif[2], e_bub[2], e_fbk[2];

  always #5 clk = ~clk;

  pipeline_stall_controller #(
    .FLUSH_CYCLES(2),
    .MEM_TIMEOUT (4),
    .CNT_W       (16)
  ) dut0 (
    .clk            (clk),
    .rst_n          (rst_n),
    .hazard_detected(hazard_detected),
    .branch_taken   (branch_taken),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .cnt_clr        (cnt_clr),
    .freeze_pc      (o_fpc[0]),
    .freeze_if_id   (o_fif[0]),
    .flush_if_id    (o_flif[0]),
    .bubble_id_exe  (o_bub[0]),
    .freeze_back    (o_fbk[0]),
    .mem_timeout    (o_mto[0]),
    .stall_cnt      (sc0),
    .flush_cnt      (fc0),
    .memwait_cnt    (mw0)
  );

  pipeline_stall_controller #(
    .FLUSH_CYCLES(3),
    .MEM_TIMEOUT (6),
    .CNT_W       (2)
  ) dut1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .hazard_detected(hazard_detected),
    .branch_taken   (branch_taken),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .cnt_clr        (cnt_clr),
    .freeze_pc      (o_fpc[1]),
    .freeze_if_id   (o_fif[1]),
    .flush_if_id    (o_flif[1]),
    .bubble_id_exe  (o_bub[1]),
    .freeze_back    (o_fbk[1]),
    .mem_timeout    (o_mto[1]),
    .stall_cnt      (sc1),
    .flush_cnt      (fc1),
    .memwait_cnt    (mw1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_add(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_waiting[i] = 1'b0;
      m_flush_left[i] = 0;
      m_wait[i] = 0;
      m_to[i] = 1'b0;
      m_stall[i] = 0;
      m_flush[i] = 0;
      m_memw[i] = 0;
    end
  endtask

  // One clock of behaviour: expected controls for this cycle, then the post-edge state.
  task automatic model_cycle(input int i);
    e_fpc[i] = 0; e_fif[i] = 0; e_flif[i] = 0; e_bub[i] = 0; e_fbk[i] = 0;
    if (m_waiting[i] ? !mem_ready : (mem_req && !mem_ready)) begin
      e_fpc[i] = 1; e_fif[i] = 1; e_fbk[i] = 1;
      m_waiting[i] = 1'b1;
      m_wait[i] = (m_wait[i] >= p_mt[i]) ? p_mt[i] : m_wait[i] + 1;
      if (m_wait[i] >= p_mt[i]) m_to[i] = 1'b1;
      m_memw[i] = sat_add(m_memw[i], p_max[i]);
    end else if (m_waiting[i]) begin
      m_waiting[i] = 1'b0;
      m_wait[i] = 0;
    end else if (branch_taken) begin
      e_flif[i] = 1; e_bub[i] = 1;
      m_flush[i] = sat_add(m_flush[i], p_max[i]);
      m_flush_left[i] = p_fc[i] - 1;
    end else if (m_flush_left[i] > 0) begin
      e_flif[i] = 1;
      m_flush_left[i]--;
    end else if (hazard_detected) begin
      e_fpc[i] = 1; e_fif[i] = 1; e_bub[i] = 1;
      m_stall[i] = sat_add(m_stall[i], p_max[i]);
    end
    if (cnt_clr) begin
      m_stall[i] = 0;
      m_flush[i] = 0;
      m_memw[i] = 0;
    end
  endtask

  task automatic check_ctrl(input int i, input string pfx);
    check_eq($sformatf("%s freeze_pc[%0d]", pfx, i), 32'(o_fpc[i]), 32'(e_fpc[i]));
    check_eq($sformatf("%s freeze_if_id[%0d]", pfx, i), 32'(o_fif[i]), 32'(e_fif[i]));
    check_eq($sformatf("%s flush_if_id[%0d]", pfx, i), 32'(o_flif[i]), 32'(e_flif[i]));
    check_eq($sformatf("%s bubble_id_exe[%0d]", pfx, i), 32'(o_bub[i]), 32'(e_bub[i]));
    check_eq($sformatf("%s freeze_back[%0d]", pfx, i), 32'(o_fbk[i]), 32'(e_fbk[i]));
  endtask

  task automatic check_regs(input int i, input string pfx);
    logic [31:0] s, f, w;
    s = (i == 0) ? 32'(sc0) : 32'(sc1);
    f = (i == 0) ? 32'(fc0) : 32'(fc1);
    w = (i == 0) ? 32'(mw0) : 32'(mw1);
    check_eq($sformatf("%s stall_cnt[%0d]", pfx, i), s, 32'(m_stall[i]));
    check_eq($sformatf("%s flush_cnt[%0d]", pfx, i), f, 32'(m_flush[i]));
    check_eq($sformatf("%s memwait_cnt[%0d]", pfx, i), w, 32'(m_memw[i]));
    check_eq($sformatf("%s mem_timeout[%0d]", pfx, i), 32'(o_mto[i]), 32'(m_to[i]));
  endtask

  task automatic step(input logic h, input logic b, input logic rq, input logic rd,
                      input logic c, input string pfx);
    @(negedge clk);
    hazard_detected = h;
    branch_taken = b;
    mem_req = rq;
    mem_ready = rd;
    cnt_clr = c;
    #2;
    for (int i = 0; i < 2; i++) begin
      model_cycle(i);
      check_ctrl(i, pfx);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) check_regs(i, pfx);
  endtask

  // Reset is dropped mid-cycle with stall-provoking inputs to prove outputs are gated.
  task automatic do_reset(input string pfx);
    @(negedge clk);
    hazard_detected = 1'b1;
    branch_taken = 1'b1;
    mem_req = 1'b1;
    mem_ready = 1'b0;
    cnt_clr = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 2; k++) begin
        e_fpc[k] = 0; e_fif[k] = 0; e_flif[k] = 0; e_bub[k] = 0; e_fbk[k] = 0;
      end
      check_ctrl(i, pfx);
      check_regs(i, pfx);
    end
    hazard_detected = 1'b0;
    branch_taken = 1'b0;
    mem_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset("reset");

    // Two hazard cycles
    step(1, 0, 0, 0, 0, "hz1");
    step(1, 0, 0, 0, 0, "hz2");
    check_eq("hz stall_cnt", 32'(sc0), 32'd2);
    step(0, 0, 0, 0, 0, "hz_idle");

    // Branch and hazard together, two-cycle flush on dut0
    do_reset("reset2");
    step(1, 1, 0, 0, 0, "br1");
    check_eq("br flush_cnt", 32'(fc0), 32'd1);
    step(1, 0, 0, 0, 0, "br2");
    check_eq("br stall_cnt", 32'(sc0), 32'd0);
    step(0, 0, 0, 0, 0, "br3");
    step(0, 0, 0, 0, 0, "br4");

    // Three wait cycles, then ready
    do_reset("reset3");
    for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 0, "mw");
    step(0, 0, 1, 1, 0, "mw_rdy");
    check_eq("mw memwait_cnt", 32'(mw0), 32'd3);

    // Branch held during a memory wait resolves after ready
    do_reset("reset4");
    step(0, 1, 1, 0, 0, "mwbr1");
    step(0, 1, 1, 0, 0, "mwbr2");
    step(0, 1, 1, 1, 0, "mwbr_rdy");
    step(0, 1, 0, 0, 0, "mwbr_flush");
    check_eq("mwbr flush seen", 32'(m_flush[0]), 32'd1);
    step(0, 0, 0, 0, 0, "mwbr_tail");
    step(0, 0, 0, 0, 0, "mwbr_tail2");

    // Timeout after the fourth wait cycle on dut0, sticky after ready
    do_reset("reset5");
    for (int k = 1; k <= 6; k++) begin
      step(0, 0, 1, 0, 0, "to");
      check_eq($sformatf("to step%0d", k), 32'(o_mto[0]), (k >= 4) ? 32'd1 : 32'd0);
    end
    step(0, 0, 1, 1, 0, "to_rdy");
    step(0, 0, 0, 0, 0, "to_idle");
    check_eq("to sticky", 32'(o_mto[0]), 32'd1);

    // Saturation on the 2-bit dut1, clear priority, reset mid-wait
    do_reset("reset6");
    for (int k = 0; k < 5; k++) step(1, 0, 0, 0, 0, "sat");
    check_eq("sat stall_cnt", 32'(sc1), 32'd3);
    step(1, 0, 0, 0, 1, "clr");
    check_eq("clr stall_cnt", 32'(sc1), 32'd0);
    step(0, 0, 1, 0, 0, "mid1");
    step(0, 0, 1, 0, 0, "mid2");
    do_reset("reset_mid");
    step(0, 0, 0, 0, 0, "post_rst");
    step(1, 0, 0, 0, 0, "post_rst_hz");

    // Mid-flush reset on dut1 (three-cycle flush)
    step(0, 1, 0, 0, 0, "fl_start");
    do_reset("reset_fl");
    step(0, 0, 0, 0, 0, "fl_gone");

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic h, b, rq, rd, c;
      h = ($urandom_range(0, 99) < 30);
      b = ($urandom_range(0, 99) < 15);
      rq = ($urandom_range(0, 99) < 40);
      rd = ($urandom_range(0, 99) < 35);
      c = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 999) < 4) do_reset("rnd_reset");
      else step(h, b, rq, rd, c, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
